// File: rtl/breakout_pkg.sv
// Shared constants for the breakout controller and its text overlay:
// FSM state codes, default game parameters and the pause-timer width.
package breakout_pkg;
  localparam int MAX_LIVES_DEF   = 3;
  localparam int TIMER_TICKS_DEF = 120;
  localparam int TIMER_W         = 8;

  typedef enum logic [2:0] {
    NEWGAME = 3'd0,
    PLAY    = 3'd1,
    NEWBALL = 3'd2,
    OVER    = 3'd3,
    WIN     = 3'd4
  } state_e;
endpackage

// File: rtl/breakout_ctrl_if.sv
// Game-control bundle between the graphics datapath (master) and the
// breakout controller (slave).
interface breakout_ctrl_if;
  logic [4:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       all_cleared;
  logic       gra_still;
  logic [2:0] game_state;
  logic [7:0] score_bcd;
  logic [1:0] lives;

  modport master (
    output btn, refr_tick, hit, miss, all_cleared,
    input  gra_still, game_state, score_bcd, lives
  );

  modport slave (
    input  btn, refr_tick, hit, miss, all_cleared,
    output gra_still, game_state, score_bcd, lives
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear and count enable;
// 99 wraps to 00.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] bcd_o
);
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (clr_i) begin
      units_d = 4'd0;
      tens_d  = 4'd0;
    end else if (en_i) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign bcd_o = {tens_q, units_q};
endmodule

// File: rtl/breakout_ctrl.sv
// Breakout game sequencer: game FSM, pause timer and lives counter; the
// score lives in a bcd2_counter that only counts hit edges during PLAY.
module breakout_ctrl
  import breakout_pkg::*;
#(
  parameter int MAX_LIVES   = MAX_LIVES_DEF,
  parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  breakout_ctrl_if.slave  bus
);
  localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [TIMER_W-1:0] TMR_LOAD   = TIMER_W'(TIMER_TICKS);
  localparam logic [TIMER_W-1:0] TMR_ONE    = TIMER_W'(1);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [1:0]         lives_q;
  logic               hit_q;

  logic pressed, hit_rise, tmr_zero;
  assign pressed  = |bus.btn;
  assign hit_rise = bus.hit & ~hit_q;
  assign tmr_zero = (timer_q == '0);

  // Timer decrement is written first so a load from PLAY overrides it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= NEWGAME;
      lives_q <= LIVES_INIT;
      timer_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= bus.hit;
      if (bus.refr_tick && !tmr_zero) timer_q <= timer_q - TMR_ONE;
      case (state_q)
        NEWGAME: begin
          lives_q <= LIVES_INIT;
          if (pressed) state_q <= PLAY;
        end
        PLAY: begin
          if (bus.all_cleared) begin
            state_q <= WIN;
            timer_q <= TMR_LOAD;
          end else if (bus.miss) begin
            timer_q <= TMR_LOAD;
            if (lives_q <= 2'd1) begin
              state_q <= OVER;
              lives_q <= 2'd0;
            end else begin
              state_q <= NEWBALL;
              lives_q <= lives_q - 2'd1;
            end
          end
        end
        NEWBALL: if (tmr_zero && pressed) state_q <= PLAY;
        OVER, WIN: if (tmr_zero) state_q <= NEWGAME;
        default: state_q <= NEWGAME;
      endcase
    end
  end

  bcd2_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_q == NEWGAME),
    .en_i    ((state_q == PLAY) && hit_rise),
    .bcd_o   (bus.score_bcd)
  );

  assign bus.gra_still  = (state_q != PLAY);
  assign bus.game_state = state_q;
  assign bus.lives      = lives_q;
endmodule

// File: tb/tb_breakout_ctrl.sv
// Self-checking bench for breakout_ctrl: directed game scenarios plus a
// randomized run compared cycle by cycle against a behavioural game model.
module tb_breakout_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  breakout_ctrl_if bif ();

  breakout_ctrl #(.MAX_LIVES(3), .TIMER_TICKS(120)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: integer score 0..99, integer lives and timer.
  int m_state = 0, m_lives = 3, m_score = 0, m_timer = 0;
  bit m_hitq = 0;

  always @(posedge clk) begin : model
    int ns, nl, nsc, nt;
    bit ld, rise;
    ns = m_state; nl = m_lives; nsc = m_score; nt = m_timer; ld = 0;
    if (!reset_n) begin
      m_state <= 0; m_lives <= 3; m_score <= 0; m_timer <= 0; m_hitq <= 0;
    end else begin
      rise = bif.hit && !m_hitq;
      case (m_state)
        0: begin nl = 3; nsc = 0; if (bif.btn != 0) ns = 1; end
        1: begin
          if (rise) nsc = (m_score + 1) % 100;
          if (bif.all_cleared) begin ns = 4; ld = 1; end
          else if (bif.miss) begin
            ld = 1;
            if (m_lives == 1) begin ns = 3; nl = 0; end
            else begin ns = 2; nl = m_lives - 1; end
          end
        end
        2: if (m_timer == 0 && bif.btn != 0) ns = 1;
        3, 4: if (m_timer == 0) ns = 0;
        default: ns = 0;
      endcase
      if (ld) nt = 120;
      else if (bif.refr_tick && m_timer > 0) nt = m_timer - 1;
      m_state <= ns; m_lives <= nl; m_score <= nsc; m_timer <= nt;
      m_hitq <= bif.hit;
    end
  end

  function automatic logic [7:0] to_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic drive(input logic [4:0] b, input logic rt, input logic h,
                       input logic m, input logic ac);
    bif.btn = b; bif.refr_tick = rt; bif.hit = h; bif.miss = m; bif.all_cleared = ac;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input logic [4:0] b);
    for (int i = 0; i < n; i++) drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(2);
    checks += 4;
    if (bif.game_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bif.game_state); end
    if (bif.gra_still !== 1'b1) begin failures++; $display("FAIL reset_still got=%b exp=1", bif.gra_still); end
    if (bif.lives !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", bif.lives); end
    if (bif.score_bcd !== 8'h00) begin failures++; $display("FAIL reset_score got=%h exp=00", bif.score_bcd); end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_start;
    drive(5'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks += 4;
    if (bif.game_state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", bif.game_state); end
    if (bif.gra_still !== 1'b0) begin failures++; $display("FAIL start_still got=%b exp=0", bif.gra_still); end
    if (bif.lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", bif.lives); end
    if (bif.score_bcd !== 8'h00) begin failures++; $display("FAIL start_score got=%h exp=00", bif.score_bcd); end
  endtask

  task automatic test_hits;
    for (int i = 0; i < 3; i++) drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bif.score_bcd !== 8'h02) begin failures++; $display("FAIL hit_edges got=%h exp=02", bif.score_bcd); end
    for (int i = 0; i < 6; i++) begin
      drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (bif.score_bcd !== 8'h08) begin failures++; $display("FAIL hit_to08 got=%h exp=08", bif.score_bcd); end
    for (int i = 0; i < 12; i++) begin
      drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1) begin
        checks++;
        if (bif.score_bcd !== 8'h10) begin failures++; $display("FAIL hit_carry got=%h exp=10", bif.score_bcd); end
      end
    end
    checks++;
    if (bif.score_bcd !== 8'h20) begin failures++; $display("FAIL hit_to20 got=%h exp=20", bif.score_bcd); end
  endtask

  task automatic test_miss;
    drive(5'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (bif.game_state !== 3'd2) begin failures++; $display("FAIL miss_state got=%0d exp=2", bif.game_state); end
    if (bif.lives !== 2'd2) begin failures++; $display("FAIL miss_lives got=%0d exp=2", bif.lives); end
    ticks(119, 5'h4);
    checks++;
    if (bif.game_state !== 3'd2) begin failures++; $display("FAIL miss_early_btn got=%0d exp=2", bif.game_state); end
    ticks(1, 5'h4);
    checks++;
    if (bif.game_state !== 3'd2) begin failures++; $display("FAIL miss_last_tick got=%0d exp=2", bif.game_state); end
    drive(5'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bif.game_state !== 3'd1) begin failures++; $display("FAIL miss_resume got=%0d exp=1", bif.game_state); end
    if (bif.score_bcd !== 8'h20) begin failures++; $display("FAIL miss_score_held got=%h exp=20", bif.score_bcd); end
  endtask

  task automatic test_over;
    drive(5'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(120, 5'h0);
    drive(5'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bif.game_state !== 3'd1) begin failures++; $display("FAIL over_resume got=%0d exp=1", bif.game_state); end
    if (bif.lives !== 2'd1) begin failures++; $display("FAIL over_lives1 got=%0d exp=1", bif.lives); end
    drive(5'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks += 3;
    if (bif.game_state !== 3'd3) begin failures++; $display("FAIL over_state got=%0d exp=3", bif.game_state); end
    if (bif.lives !== 2'd0) begin failures++; $display("FAIL over_lives0 got=%0d exp=0", bif.lives); end
    if (bif.score_bcd !== 8'h20) begin failures++; $display("FAIL over_score got=%h exp=20", bif.score_bcd); end
    for (int i = 0; i < 120; i++) drive(5'h0, 1'b1, 1'(i % 2), 1'b1, 1'b0);
    checks += 3;
    if (bif.game_state !== 3'd3) begin failures++; $display("FAIL over_hold got=%0d exp=3", bif.game_state); end
    if (bif.score_bcd !== 8'h20) begin failures++; $display("FAIL over_hit_ignored got=%h exp=20", bif.score_bcd); end
    if (bif.lives !== 2'd0) begin failures++; $display("FAIL over_no_underflow got=%0d exp=0", bif.lives); end
    idle(1);
    checks++;
    if (bif.game_state !== 3'd0) begin failures++; $display("FAIL over_to_new got=%0d exp=0", bif.game_state); end
    idle(1);
    checks += 2;
    if (bif.lives !== 2'd3) begin failures++; $display("FAIL over_new_lives got=%0d exp=3", bif.lives); end
    if (bif.score_bcd !== 8'h00) begin failures++; $display("FAIL over_new_score got=%h exp=00", bif.score_bcd); end
  endtask

  task automatic test_win;
    drive(5'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks += 3;
    if (bif.game_state !== 3'd4) begin failures++; $display("FAIL win_state got=%0d exp=4", bif.game_state); end
    if (bif.lives !== 2'd3) begin failures++; $display("FAIL win_lives got=%0d exp=3", bif.lives); end
    if (bif.score_bcd !== 8'h02) begin failures++; $display("FAIL win_score got=%h exp=02", bif.score_bcd); end
    ticks(120, 5'h0);
    checks++;
    if (bif.game_state !== 3'd4) begin failures++; $display("FAIL win_hold got=%0d exp=4", bif.game_state); end
    idle(1);
    checks++;
    if (bif.game_state !== 3'd0) begin failures++; $display("FAIL win_to_new got=%0d exp=0", bif.game_state); end
  endtask

  task automatic test_reset_mid;
    drive(5'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(63, 5'h0);
    checks++;
    if (bif.score_bcd !== 8'h01) begin failures++; $display("FAIL rmid_pre_score got=%h exp=01", bif.score_bcd); end
    reset_n = 1'b0;
    drive(5'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    checks += 4;
    if (bif.game_state !== 3'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", bif.game_state); end
    if (bif.lives !== 2'd3) begin failures++; $display("FAIL rmid_lives got=%0d exp=3", bif.lives); end
    if (bif.score_bcd !== 8'h00) begin failures++; $display("FAIL rmid_score got=%h exp=00", bif.score_bcd); end
    if (bif.gra_still !== 1'b1) begin failures++; $display("FAIL rmid_still got=%b exp=1", bif.gra_still); end
  endtask

  task automatic test_random;
    logic [4:0] b;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 599) != 0);
      b = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
      drive(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      checks += 4;
      if (bif.game_state !== 3'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, bif.game_state, m_state); end
      if (bif.gra_still !== (m_state != 1)) begin failures++; $display("FAIL rnd_still cyc=%0d got=%b exp=%b", i, bif.gra_still, m_state != 1); end
      if (bif.lives !== 2'(m_lives)) begin failures++; $display("FAIL rnd_lives cyc=%0d got=%0d exp=%0d", i, bif.lives, m_lives); end
      if (bif.score_bcd !== to_bcd(m_score)) begin failures++; $display("FAIL rnd_score cyc=%0d got=%h exp=%h", i, bif.score_bcd, to_bcd(m_score)); end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    bif.btn = 5'h0; bif.refr_tick = 1'b0; bif.hit = 1'b0; bif.miss = 1'b0; bif.all_cleared = 1'b0;
    @(negedge clk);
    test_reset;
    test_start;
    test_hits;
    test_miss;
    test_over;
    test_win;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
